twiddle_addr_gen: RTL and testbench

TWIDDLE_ADDR_GEN -- requirements
Module: twiddle_addr_gen

---
 rtl/twiddle_addr_gen.sv | 146 ++++++++++++++
 tb/tb_twiddle_addr_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_addr_gen.sv
// Twiddle-factor ROM address generator for a radix-2 FFT of runtime size 2^m <= N.
// Walks stages s = 0..m-1 and butterflies b = 0..2^(m-1)-1 with a valid/ready output.
module twiddle_addr_gen #(
    parameter  int N       = 8,
    localparam int LOG2N   = $clog2(N),
    localparam int ADDR_W  = LOG2N - 1,
    localparam int STAGE_W = $clog2(LOG2N),
    localparam int CFG_W   = $clog2(LOG2N + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CFG_W-1:0]   cfg_log2n,
    input  logic               cfg_inverse,
    input  logic               abort,
    input  logic               tw_ready,
    output logic               tw_valid,
    output logic [ADDR_W-1:0]  tw_addr,
    output logic [STAGE_W-1:0] tw_stage,
    output logic               tw_last_stage_beat,
    output logic               tw_last,
    output logic               tw_inverse,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [1:0]         state_dbg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Handshake: a beat transfers on a rising clk edge where tw_valid and
    // tw_ready are both 1; while tw_ready is 0 every tw_* output holds.

    logic [1:0]         state, state_n;
    logic [CFG_W-1:0]   m_q, m_n;
    logic [STAGE_W-1:0] s_q, s_n;
    logic [ADDR_W-1:0]  b_q, b_n;
    logic               inv_n, err_n, hs, run_n;

    function automatic logic [ADDR_W-1:0] beat_max_of(input logic [CFG_W-1:0] m);
        logic [31:0] v;
        v = (32'd1 << (32'(m) - 32'd1)) - 32'd1;
        return v[ADDR_W-1:0];
    endfunction

    function automatic logic [STAGE_W-1:0] last_s_of(input logic [CFG_W-1:0] m);
        logic [31:0] v;
        v = 32'(m) - 32'd1;
        return v[STAGE_W-1:0];
    endfunction

    // Stage s of a size-2^m transform uses every 2^(s+LOG2N-m)-th entry of the full ROM.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0]  b,
                                                  input logic [STAGE_W-1:0] s,
                                                  input logic [CFG_W-1:0]   m);
        logic [31:0] mask, sh, full;
        mask = (32'd1 << (32'(m) - 32'd1 - 32'(s))) - 32'd1;
        sh   = 32'(s) + 32'(LOG2N) - 32'(m);
        full = (32'(b) & mask) << sh;
        return full[ADDR_W-1:0];
    endfunction

    assign hs        = tw_valid && tw_ready;
    assign run_n     = (state_n == RUN);
    assign state_dbg = state;

    always_comb begin
        state_n = state;
        m_n     = m_q;
        s_n     = s_q;
        b_n     = b_q;
        inv_n   = tw_inverse;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (cfg_log2n != '0 && 32'(cfg_log2n) <= 32'(LOG2N)) begin
                        m_n     = cfg_log2n;
                        inv_n   = cfg_inverse;
                        s_n     = '0;
                        b_n     = '0;
                        state_n = RUN;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    s_n     = '0;
                    b_n     = '0;
                end else if (hs) begin
                    if (b_q == beat_max_of(m_q)) begin
                        if (s_q == last_s_of(m_q)) begin
                            state_n = DONE;
                        end else begin
                            s_n = s_q + STAGE_W'(1);
                            b_n = '0;
                        end
                    end else begin
                        b_n = b_q + ADDR_W'(1);
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            m_q                <= '0;
            s_q                <= '0;
            b_q                <= '0;
            tw_valid           <= 1'b0;
            tw_addr            <= '0;
            tw_stage           <= '0;
            tw_last_stage_beat <= 1'b0;
            tw_last            <= 1'b0;
            tw_inverse         <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            cfg_err            <= 1'b0;
        end else begin
            state              <= state_n;
            m_q                <= m_n;
            s_q                <= s_n;
            b_q                <= b_n;
            tw_valid           <= run_n;
            tw_addr            <= run_n ? addr_of(b_n, s_n, m_n) : '0;
            tw_stage           <= run_n ? s_n : '0;
            tw_last_stage_beat <= run_n && (b_n == beat_max_of(m_n));
            tw_last            <= run_n && (b_n == beat_max_of(m_n)) && (s_n == last_s_of(m_n));
            tw_inverse         <= inv_n;
            busy               <= (state_n != IDLE);
            done               <= (state_n == DONE);
            cfg_err            <= err_n;
        end
    end

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Randomized bench for twiddle_addr_gen: expected beats come from a per-transform
// list built with plain arithmetic and are consumed as handshakes occur.
module tb_twiddle_addr_gen;

    localparam int N       = 8;
    localparam int LOG2N   = $clog2(N);
    localparam int ADDR_W  = LOG2N - 1;
    localparam int STAGE_W = $clog2(LOG2N);
    localparam int CFG_W   = $clog2(LOG2N + 1);
    localparam int PW      = ADDR_W + STAGE_W + 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [CFG_W-1:0]   cfg_log2n = '0;
    logic               cfg_inverse = 1'b0;
    logic               abort = 1'b0;
    logic               tw_ready = 1'b0;
    logic               tw_valid;
    logic [ADDR_W-1:0]  tw_addr;
    logic [STAGE_W-1:0] tw_stage;
    logic               tw_last_stage_beat, tw_last, tw_inverse;
    logic               busy, done, cfg_err;
    logic [1:0]         state_dbg;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q[$];

    twiddle_addr_gen #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_log2n(cfg_log2n),
        .cfg_inverse(cfg_inverse), .abort(abort), .tw_ready(tw_ready),
        .tw_valid(tw_valid), .tw_addr(tw_addr), .tw_stage(tw_stage),
        .tw_last_stage_beat(tw_last_stage_beat), .tw_last(tw_last),
        .tw_inverse(tw_inverse), .busy(busy), .done(done), .cfg_err(cfg_err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: twiddle index for butterfly b of stage s in a size-2^m FFT,
    // expressed as an index into the size-N table of N/2 entries.
    function automatic logic [PW-1:0] beat_word(input int m, input int s, input int b);
        int  half, grp, stride, addr;
        bit  lsb, last;
        half   = 1 << (m - 1);
        grp    = 1 << (m - 1 - s);
        stride = N / (1 << m) * (1 << s);
        addr   = ((b % grp) * stride) % (N / 2);
        lsb    = (b == half - 1);
        last   = lsb && (s == m - 1);
        return {ADDR_W'(addr), STAGE_W'(s), lsb, last};
    endfunction

    function automatic logic [31:0] out_word();
        return 32'({tw_valid, tw_addr, tw_stage, tw_last_stage_beat, tw_last,
                    tw_inverse, busy, done, cfg_err, state_dbg});
    endfunction

    task automatic build_expected(input int m);
        exp_q.delete();
        for (int s = 0; s < m; s++)
            for (int b = 0; b < (1 << (m - 1)); b++)
                exp_q.push_back(beat_word(m, s, b));
    endtask

    // Called at a negedge. abort_beat < 0 means run to completion.
    task automatic run_seq(input int m, input bit inv, input int stall_pct,
                           input int abort_beat, input bit poke_start);
        int beats, cyc, total, stalls;
        logic [PW-1:0] got, prev;
        bit stalled, fin, aborted;
        build_expected(m);
        total = exp_q.size();
        cfg_log2n = CFG_W'(m);
        cfg_inverse = inv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("valid_rise", 32'(tw_valid), 1);
        check_eq("busy_run", 32'(busy), 1);
        check_eq("inverse_latch", 32'(tw_inverse), 32'(inv));
        beats = 0; cyc = 0; stalls = 0; stalled = 0; fin = 0; aborted = 0; prev = '0;
        while (!fin && cyc < 400) begin
            got = {tw_addr, tw_stage, tw_last_stage_beat, tw_last};
            if (stalled) check_eq("stall_hold", 32'(got), 32'(prev));
            if (!tw_valid) begin
                check_eq("valid_gap", 32'(tw_valid), 1);
                fin = 1;
            end else begin
                tw_ready = ($urandom_range(99) >= stall_pct);
                start = poke_start && ($urandom_range(3) == 0);
                cfg_log2n = CFG_W'($urandom_range(LOG2N));
                if (tw_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_beat", 32'(beats + 1), 32'(total));
                        fin = 1;
                    end else begin
                        check_eq("beat", 32'(got), 32'(exp_q.pop_front()));
                    end
                    if (beats == abort_beat) begin
                        abort = 1'b1;
                        aborted = 1;
                    end
                    beats++;
                    if (aborted || exp_q.size() == 0) fin = 1;
                end else begin
                    stalls++;
                end
                stalled = !tw_ready;
                prev = got;
            end
            @(negedge clk);
            cyc++;
        end
        tw_ready = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        if (cyc >= 400) check_eq("timeout", 32'(cyc), 32'(total));
        if (aborted) begin
            check_eq("abort_valid", 32'(tw_valid), 0);
            check_eq("abort_busy", 32'(busy), 0);
            check_eq("abort_done", 32'(done), 0);
            @(negedge clk);
            check_eq("abort_no_done", 32'(done), 0);
        end else begin
            check_eq("valid_fall", 32'(tw_valid), 0);
            check_eq("done_pulse", 32'(done), 1);
            check_eq("busy_done", 32'(busy), 1);
            check_eq("beat_count", 32'(beats), 32'(total));
            check_eq("throughput", 32'(cyc - stalls), 32'(total));
            @(negedge clk);
            check_eq("done_one_cycle", 32'(done), 0);
            check_eq("busy_idle", 32'(busy), 0);
            check_eq("inverse_hold", 32'(tw_inverse), 32'(inv));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", out_word(), 0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("idle_after_reset", out_word(), 0);

        // Directed sizes at full throughput
        run_seq(3, 1'b0, 0, -1, 1'b0);
        run_seq(2, 1'b1, 0, -1, 1'b0);
        run_seq(1, 1'b0, 0, -1, 1'b0);

        // Bad configuration
        cfg_log2n = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("cfg_err_pulse", 32'(cfg_err), 1);
        check_eq("cfg_err_busy", 32'(busy), 0);
        check_eq("cfg_err_valid", 32'(tw_valid), 0);
        @(negedge clk);
        check_eq("cfg_err_clear", 32'(cfg_err), 0);

        // abort with start in IDLE discards start
        cfg_log2n = CFG_W'(3); start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("abort_start_idle", 32'({busy, tw_valid, cfg_err}), 0);

        // Stalls, ignored starts, abort on beat 5 then replay
        run_seq(3, 1'b1, 40, -1, 1'b1);
        run_seq(3, 1'b0, 0, 4, 1'b0);
        run_seq(3, 1'b0, 0, -1, 1'b0);

        // Reset in the middle of stage 1
        cfg_log2n = CFG_W'(3); cfg_inverse = 1'b1; tw_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("mid_stage", 32'(tw_stage), 1);
        #2 reset = 1'b0;
        #1 check_eq("reset_async", out_word(), 0);
        tw_ready = 1'b0;
        @(negedge clk);
        check_eq("reset_no_done", 32'(done), 0);
        reset = 1'b1;
        run_seq(3, 1'b0, 0, -1, 1'b0);

        // Random transforms
        for (int i = 0; i < 8; i++) begin
            run_seq($urandom_range(LOG2N, 1), 1'($urandom_range(1)),
                    $urandom_range(50), -1, 1'($urandom_range(1)));
            repeat ($urandom_range(2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
